// File: rtl/perf_stat_bank.sv
// perf_stat_bank: NUM_CH event counters (wrap or saturate, sticky ovf, halt-driven freeze), 1-cycle registered read.
// Define PERF_STAT_SNAPSHOT_EN to add the snapshot shadow bank; without it reads return the live counters.
module perf_stat_bank #(
  parameter int CNT_W    = 32,
  parameter int NUM_CH   = 4,
  parameter int SATURATE = 0,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ev,
  input  logic              halt,
  input  logic              clr,
  input  logic              snap,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] ovf,
  output logic              frozen
);

  typedef enum logic {ST_RUN = 1'b0, ST_FROZEN = 1'b1} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q [NUM_CH];
  logic [CNT_W-1:0]    cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0]    rd_bank [NUM_CH];
  logic [CNT_W-1:0]    rd_src;
  logic [CNT_W-1:0]    rd_data_q;
  logic                rd_valid_q;

  // Events are still counted on the edge that first samples halt; the freeze applies afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    if (!clr && halt) state_q <= ST_FROZEN;
        ST_FROZEN: if (clr)          state_q <= ST_RUN;
        default:                     state_q <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
      ovf_d = '0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ev[i]) begin
          if (&cnt_q[i]) begin
            ovf_d[i] = 1'b1;
            cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef PERF_STAT_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_q [NUM_CH];

  // Captures the pre-edge counter values, so a same-cycle clr or event is not seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else if (snap) begin
      shadow_q <= cnt_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) rd_bank[i] = shadow_q[i];
  end
`else
  logic unused_snap;
  assign unused_snap = snap;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) rd_bank[i] = cnt_q[i];
  end
`endif

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_src = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rd_sel) == i) rd_src = rd_bank[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_src;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ovf      = ovf_q;
  assign frozen   = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_perf_stat_bank.sv
// Bench: two 4-bit, 5-channel instances (wrap and saturate) driven in lockstep against a behavioural model.
module tb_perf_stat_bank;
  localparam int W    = 4;
  localparam int NCH  = 5;
  localparam int SW   = 3;
  localparam int MAXV = (1 << W) - 1;

  logic            clk;
  logic            reset;
  logic [NCH-1:0]  ev;
  logic            halt, clr, snap, rd_en;
  logic [SW-1:0]   rd_sel;
  logic [W-1:0]    rd_data_w  [2];
  logic            rd_valid_w [2];
  logic [NCH-1:0]  ovf_w      [2];
  logic            frozen_w   [2];

  int checks;
  int failures;

  // Model state: index 0 = wrap instance, 1 = saturate instance.
  int m_cnt [2][NCH];
  int m_sh  [2][NCH];
  bit m_ovf [2][NCH];
  bit m_frz [2];
  int m_rd  [2];
  bit m_rv  [2];

  perf_stat_bank #(.CNT_W(W), .NUM_CH(NCH), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .ev(ev), .halt(halt), .clr(clr), .snap(snap),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]),
    .ovf(ovf_w[0]), .frozen(frozen_w[0])
  );

  perf_stat_bank #(.CNT_W(W), .NUM_CH(NCH), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .ev(ev), .halt(halt), .clr(clr), .snap(snap),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]),
    .ovf(ovf_w[1]), .frozen(frozen_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[k][i] = 0;
        m_sh[k][i]  = 0;
        m_ovf[k][i] = 1'b0;
      end
      m_frz[k] = 1'b0;
      m_rd[k]  = 0;
      m_rv[k]  = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs currently applied.
  task automatic model_step();
    int old [NCH];
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NCH; i++) old[i] = m_cnt[k][i];
      if (rd_en) begin
        m_rv[k] = 1'b1;
        if (int'(rd_sel) >= NCH) m_rd[k] = 0;
`ifdef PERF_STAT_SNAPSHOT_EN
        else m_rd[k] = m_sh[k][rd_sel];
`else
        else m_rd[k] = old[rd_sel];
`endif
      end else begin
        m_rv[k] = 1'b0;
      end
`ifdef PERF_STAT_SNAPSHOT_EN
      if (snap) for (int i = 0; i < NCH; i++) m_sh[k][i] = old[i];
`endif
      if (clr) begin
        for (int i = 0; i < NCH; i++) begin
          m_cnt[k][i] = 0;
          m_ovf[k][i] = 1'b0;
        end
        m_frz[k] = 1'b0;
      end else if (!m_frz[k]) begin
        for (int i = 0; i < NCH; i++) begin
          if (ev[i]) begin
            if (old[i] == MAXV) begin
              m_ovf[k][i] = 1'b1;
              m_cnt[k][i] = (k == 1) ? MAXV : 0;
            end else begin
              m_cnt[k][i] = old[i] + 1;
            end
          end
        end
        if (halt) m_frz[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_ovf;
    for (int k = 0; k < 2; k++) begin
      exp_ovf = 0;
      for (int i = 0; i < NCH; i++) if (m_ovf[k][i]) exp_ovf |= (1 << i);
      chk($sformatf("%s/i%0d/rd_valid", tag, k), rd_valid_w[k], m_rv[k]);
      chk($sformatf("%s/i%0d/rd_data", tag, k), rd_data_w[k], m_rd[k]);
      chk($sformatf("%s/i%0d/ovf", tag, k), ovf_w[k], exp_ovf);
      chk($sformatf("%s/i%0d/frozen", tag, k), frozen_w[k], m_frz[k]);
    end
  endtask

  task automatic cycle(input string tag, input logic [NCH-1:0] ev_v, input logic halt_v,
                       input logic clr_v, input logic snap_v, input logic rd_en_v,
                       input logic [SW-1:0] sel_v);
    ev = ev_v; halt = halt_v; clr = clr_v; snap = snap_v; rd_en = rd_en_v; rd_sel = sel_v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic read_ch(input string tag, input int ch);
    cycle(tag, '0, 1'b0, 1'b0, 1'b0, 1'b1, SW'(ch));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    ev = '0; halt = 0; clr = 0; snap = 0; rd_en = 0; rd_sel = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // All channels count 10, then snapshot and read every channel.
    for (int n = 0; n < 10; n++) cycle("all_cnt", '1, 0, 0, 0, 0, '0);
    cycle("all_snap", '0, 0, 0, 1, 0, '0);
    for (int c = 0; c < NCH; c++) read_ch("all_rd", c);
    idle("all_idle");

    // Overflow on ch1: 17 events into a 4-bit counter.
    cycle("ovf_clr", '0, 0, 1, 0, 0, '0);
    for (int n = 0; n < 17; n++) cycle("ovf_cnt", 5'b00010, 0, 0, 0, 0, '0);
    cycle("ovf_snap", '0, 0, 0, 1, 0, '0);
    read_ch("ovf_rd", 1);

    // Halt pulse while ch0 counts, then release only by clr.
    cycle("halt_clr", '0, 0, 1, 0, 0, '0);
    for (int n = 0; n < 5; n++) cycle("halt_pre", 5'b00001, 0, 0, 0, 0, '0);
    cycle("halt_hit", 5'b00001, 1, 0, 0, 0, '0);
    for (int n = 0; n < 10; n++) cycle("halt_post", 5'b00001, 0, 0, 0, 0, '0);
    cycle("halt_snap", 5'b00001, 0, 0, 1, 0, '0);
    read_ch("halt_rd", 0);
    cycle("halt_rel", 5'b00001, 0, 1, 0, 0, '0);
    for (int n = 0; n < 3; n++) cycle("halt_recnt", 5'b00001, 0, 0, 0, 0, '0);
    cycle("halt_snap2", '0, 0, 0, 1, 0, '0);
    read_ch("halt_rd2", 0);

    // clr and snap on the same edge: snapshot keeps the pre-clear count.
    for (int n = 0; n < 7; n++) cycle("cs_cnt", 5'b00100, 0, 0, 0, 0, '0);
    cycle("cs_both", 5'b00100, 0, 1, 1, 0, '0);
    read_ch("cs_rd", 2);
    for (int n = 0; n < 3; n++) cycle("cs_cnt2", 5'b00100, 0, 0, 0, 0, '0);
    cycle("cs_snap2", '0, 0, 0, 1, 1, 3'd2);
    read_ch("cs_rd2", 2);

    // Out-of-range selects and back-to-back reads.
    for (int s = NCH; s < 8; s++) read_ch("oor_rd", s);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      cycle("rand", NCH'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
            SW'($urandom_range(0, 7)));
    end

    // Asynchronous reset in the middle of a read pulse.
    ev = '1; halt = 0; clr = 0; snap = 0; rd_en = 1; rd_sel = 3'd0;
    @(posedge clk);
    model_step();
    #2;
    chk("midrd/rd_valid_pre", rd_valid_w[0], m_rv[0]);
    reset = 1'b0;
    model_reset();
    #1;
    check_all("midrd_reset");
    @(negedge clk);
    reset = 1'b1;
    rd_en = 0;
    cycle("post_reset", 5'b01000, 0, 0, 0, 0, '0);
    cycle("post_reset_rd", '0, 0, 0, 1, 1, 3'd3);
    read_ch("post_reset_rd2", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
